uart_hex_tx: RTL and testbench

//   Parametrised hex-dump transmitter for the UART monitor path. Queues dump requests
//   (word + end-of-line flags) and serialises each as ASCII hex digits, with a space

---
 rtl/uart_mon_pkg.sv | 34 +++
 rtl/uart_hex_fifo.sv | 46 ++++
 rtl/uart_hex_tx.sv | 146 ++++++++++++++
 tb/tb_uart_hex_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mon_pkg.sv
// rtl/uart_mon_pkg.sv - ASCII constants, hex FSM states and nibble encoder for the UART monitor path.
// UART_HEX_UPPER_EN selects upper-case a..f.
package uart_mon_pkg;

    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_A_LO = 8'h61;
    localparam logic [7:0] CH_A_UP = 8'h41;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_CR   = 8'h0d;
    localparam logic [7:0] CH_LF   = 8'h0a;

    typedef enum logic [2:0] {
        IDLE,
        DIGIT,
        SPACE,
        CR,
        LF
    } hex_st_t;

    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] w_alpha;
`ifdef UART_HEX_UPPER_EN
        w_alpha = CH_A_UP;
`else
        w_alpha = CH_A_LO;
`endif
        if (nib < 4'd10) begin
            nib2ascii = CH_0 + {4'h0, nib};
        end else begin
            nib2ascii = w_alpha + {4'h0, nib - 4'd10};
        end
    endfunction

endpackage

// File: rtl/uart_hex_fifo.sv
// rtl/uart_hex_fifo.sv - Request queue for the hex-dump transmitter, show-ahead read.
module uart_hex_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push;
    logic             w_pop;

    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign empty = (r_wptr == r_rptr);
    assign dout  = r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/uart_hex_tx.sv
// rtl/uart_hex_tx.sv - Queued hex-dump transmitter: words to grouped ASCII hex with optional CR LF.
// UART_HEX_UPPER_EN (via uart_mon_pkg) selects upper-case a..f.
module uart_hex_tx
    import uart_mon_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int GROUP  = 2,
    parameter int QDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_eol,
    input  logic              req_eolonly,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [7:0]        tx_char,
    output logic              busy,
    output logic              done
);

    localparam int NDIG = DATA_W / 4;
    localparam int DCW  = $clog2(NDIG + 1);
    localparam int FW   = DATA_W + 2;

    hex_st_t           r_state;
    hex_st_t           w_nx_state;
    logic [DCW-1:0]    r_dcnt;
    logic [DCW-1:0]    w_nx_dcnt;
    logic [DATA_W-1:0] r_hold;
    logic              r_hold_eol;
    logic              r_tx_valid;
    logic [7:0]        r_tx_char;
    logic              w_nx_valid;
    logic [7:0]        w_nx_char;
    logic              w_fire;
    logic              w_last;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [FW-1:0]     w_fifo_dout;

    uart_hex_fifo #(
        .WIDTH (FW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid),
        .pop   (w_pop),
        .din   ({req_eolonly, req_eol, req_data}),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_fire = r_tx_valid & tx_ready;

    always_comb begin
        w_nx_state = r_state;
        w_nx_dcnt  = r_dcnt;
        w_last     = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_fifo_dout[FW-1]) begin
                        w_nx_state = CR;
                    end else begin
                        w_nx_state = DIGIT;
                        w_nx_dcnt  = DCW'(NDIG - 1);
                    end
                end
            end
            DIGIT: begin
                if (w_fire) begin
                    if (r_dcnt == '0) begin
                        if (r_hold_eol) begin
                            w_nx_state = CR;
                        end else begin
                            w_nx_state = IDLE;
                            w_last     = 1'b1;
                        end
                    end else if ((int'(r_dcnt) % GROUP) == 0) begin
                        w_nx_state = SPACE;
                        w_nx_dcnt  = r_dcnt - 1'b1;
                    end else begin
                        w_nx_dcnt  = r_dcnt - 1'b1;
                    end
                end
            end
            SPACE: if (w_fire) w_nx_state = DIGIT;
            CR:    if (w_fire) w_nx_state = LF;
            LF: begin
                if (w_fire) begin
                    w_nx_state = IDLE;
                    w_last     = 1'b1;
                end
            end
            default: w_nx_state = IDLE;
        endcase

        // The cycle after a pop only loads the holding regs, so the first char appears one cycle later.
        w_nx_valid = (r_state != IDLE) && (w_nx_state != IDLE);
        w_nx_char  = r_tx_char;
        if (w_nx_valid) begin
            case (w_nx_state)
                DIGIT:   w_nx_char = nib2ascii(r_hold[{w_nx_dcnt, 2'b00} +: 4]);
                SPACE:   w_nx_char = CH_SP;
                CR:      w_nx_char = CH_CR;
                LF:      w_nx_char = CH_LF;
                default: w_nx_char = r_tx_char;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dcnt     <= '0;
            r_hold     <= '0;
            r_hold_eol <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_char  <= CH_SP;
        end else begin
            r_state    <= w_nx_state;
            r_dcnt     <= w_nx_dcnt;
            r_tx_valid <= w_nx_valid;
            r_tx_char  <= w_nx_char;
            if (w_pop) begin
                r_hold     <= w_fifo_dout[DATA_W-1:0];
                r_hold_eol <= w_fifo_dout[DATA_W];
            end
        end
    end

    assign req_ready = ~w_full;
    assign tx_valid  = r_tx_valid;
    assign tx_char   = r_tx_char;
    assign busy      = (r_state != IDLE) | ~w_empty;
    assign done      = w_last;

endmodule

// File: tb/tb_uart_hex_tx.sv
// tb/tb_uart_hex_tx.sv - Scoreboard bench for uart_hex_tx (32-bit/GROUP 2 and 64-bit/GROUP 4 instances).
module tb_uart_hex_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        rv32 = 1'b0, eol32 = 1'b0, eo32 = 1'b0, tr32 = 1'b0;
    logic [31:0] rd32 = '0;
    logic        rr32, tv32, busy32, done32;
    logic [7:0]  tc32;

    logic        rv64 = 1'b0, eol64 = 1'b0, eo64 = 1'b0, tr64 = 1'b1;
    logic [63:0] rd64 = '0;
    logic        rr64, tv64, busy64, done64;
    logic [7:0]  tc64;

    uart_hex_tx #(.DATA_W(32), .GROUP(2), .QDEPTH(4)) u32 (
        .clk(clk), .rst(rst), .req_valid(rv32), .req_ready(rr32), .req_data(rd32),
        .req_eol(eol32), .req_eolonly(eo32), .tx_valid(tv32), .tx_ready(tr32),
        .tx_char(tc32), .busy(busy32), .done(done32)
    );

    uart_hex_tx #(.DATA_W(64), .GROUP(4), .QDEPTH(4)) u64 (
        .clk(clk), .rst(rst), .req_valid(rv64), .req_ready(rr64), .req_data(rd64),
        .req_eol(eol64), .req_eolonly(eo64), .tx_valid(tv64), .tx_ready(tr64),
        .tx_char(tc64), .busy(busy64), .done(done64)
    );

    int n_chk = 0;
    int n_fail = 0;
    int chars32 = 0, chars64 = 0, dones32 = 0, dones64 = 0;
    int rdy_mode = 0;
    int cyc = 0;
    logic [8:0] exp32[$];
    logic [8:0] exp64[$];
    bit         stall32 = 1'b0, stall64 = 1'b0;
    logic [7:0] held32 = '0, held64 = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\", expected \"%s\"", nm, act, exp);
        end
    endtask

    // Printed form: digits MS first, a space wherever the count of remaining digits is a multiple of grp.
    function automatic string fmt(input logic [63:0] d, input int ndig, input int grp,
                                  input bit eol, input bit eo);
        string hx;
        string s;
        if (eo) return "\015\012";
        hx = $sformatf("%016h", d);
        s = "";
        for (int k = 0; k < ndig; k++) begin
            if (k > 0 && ((ndig - k) % grp) == 0) s = {s, " "};
            s = {s, hx.substr(16 - ndig + k, 16 - ndig + k)};
        end
`ifdef UART_HEX_UPPER_EN
        s = s.toupper();
`endif
        if (eol) s = {s, "\015\012"};
        return s;
    endfunction

    always @(negedge clk) begin : mon
        string s;
        logic [8:0] e;
        if (rst) begin
            exp32.delete();
            exp64.delete();
            stall32 = 1'b0;
            stall64 = 1'b0;
        end else begin
            if (stall32) begin
                chk("hold_valid32", tv32, 1);
                chk("hold_char32", tc32, held32);
            end
            if (rv32 && rr32) begin
                s = fmt({32'h0, rd32}, 8, 2, eol32, eo32);
                for (int i = 0; i < s.len(); i++) exp32.push_back({i == s.len() - 1, s[i]});
            end
            if (tv32 && tr32) begin
                chars32++;
                if (exp32.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_char32: got %h, expected no char", tc32);
                end else begin
                    e = exp32.pop_front();
                    chk("char32", tc32, e[7:0]);
                    chk("done32", done32, e[8]);
                end
            end else begin
                chk("done_idle32", done32, 0);
            end
            if (done32) dones32++;
            stall32 = tv32 && !tr32;
            held32 = tc32;

            if (stall64) begin
                chk("hold_valid64", tv64, 1);
                chk("hold_char64", tc64, held64);
            end
            if (rv64 && rr64) begin
                s = fmt(rd64, 16, 4, eol64, eo64);
                for (int i = 0; i < s.len(); i++) exp64.push_back({i == s.len() - 1, s[i]});
            end
            if (tv64 && tr64) begin
                chars64++;
                if (exp64.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_char64: got %h, expected no char", tc64);
                end else begin
                    e = exp64.pop_front();
                    chk("char64", tc64, e[7:0]);
                    chk("done64", done64, e[8]);
                end
            end else begin
                chk("done_idle64", done64, 0);
            end
            if (done64) dones64++;
            stall64 = tv64 && !tr64;
            held64 = tc64;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (rdy_mode)
                0:       tr32 = 1'b0;
                1:       tr32 = 1'b1;
                default: tr32 = ((cyc % 3) == 0);
            endcase
        end
    end

    task automatic push32(input logic [31:0] d, input logic eol, input logic eo);
        int n = 0;
        rd32 = d; eol32 = eol; eo32 = eo; rv32 = 1'b1;
        while (!rr32 && n < 200) begin @(posedge clk); #1; n++; end
        if (!rr32) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout32: got req_ready 0, expected 1");
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic push64(input logic [63:0] d, input logic eol, input logic eo);
        int n = 0;
        rd64 = d; eol64 = eol; eo64 = eo; rv64 = 1'b1;
        while (!rr64 && n < 200) begin @(posedge clk); #1; n++; end
        if (!rr64) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout64: got req_ready 0, expected 1");
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle32(input int lim);
        int n = 0;
        @(posedge clk); #1;
        while (busy32 && n < lim) begin @(posedge clk); #1; n++; end
        if (busy32) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout32: got busy 1, expected 0");
        end
    endtask

    task automatic wait_idle64(input int lim);
        int n = 0;
        @(posedge clk); #1;
        while (busy64 && n < lim) begin @(posedge clk); #1; n++; end
        if (busy64) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout64: got busy 1, expected 0");
        end
    endtask

    initial begin
        int c0, d0;
        string t1, t2, tg;
`ifdef UART_HEX_UPPER_EN
        t1 = "12 34 AB CD\015\012";
        t2 = "0123 4567 89AB CDEF";
        tg = "0 A 5";
`else
        t1 = "12 34 ab cd\015\012";
        t2 = "0123 4567 89ab cdef";
        tg = "0 a 5";
`endif
        chk_str("model_t1", fmt(64'h1234ABCD, 8, 2, 1'b1, 1'b0), t1);
        chk_str("model_t2", fmt(64'h0123456789ABCDEF, 16, 4, 1'b0, 1'b0), t2);
        chk_str("model_eolonly", fmt(64'hFF, 8, 2, 1'b1, 1'b1), "\015\012");
        chk_str("model_group1", fmt(64'h0A5, 3, 1, 1'b0, 1'b0), tg);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready32", rr32, 1);
        chk("rst_tx_valid32", tv32, 0);
        chk("rst_tx_char32", tc32, 8'h20);
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_req_ready64", rr64, 1);
        chk("rst_tx_valid64", tv64, 0);
        chk("rst_tx_char64", tc64, 8'h20);
        rst = 1'b0;
        rdy_mode = 1;
        repeat (2) @(posedge clk);
        #1;

        // 1: latency and basic 32-bit line with CR LF
        c0 = chars32; d0 = dones32;
        push32(32'h1234ABCD, 1'b1, 1'b0);
        rv32 = 1'b0;
        chk("lat_n0", tv32, 0);
        @(posedge clk); #1;
        chk("lat_n1", tv32, 0);
        @(posedge clk); #1;
        chk("lat_n2_valid", tv32, 1);
        chk("lat_n2_char", tc32, 8'h31);
        wait_idle32(200);
        chk("t1_chars", chars32 - c0, 13);
        chk("t1_dones", dones32 - d0, 1);
        chk("t1_drained", exp32.size(), 0);

        // 2: 64-bit, GROUP 4, no eol
        c0 = chars64; d0 = dones64;
        push64(64'h0123456789ABCDEF, 1'b0, 1'b0);
        rv64 = 1'b0;
        wait_idle64(200);
        chk("t2_chars", chars64 - c0, 19);
        chk("t2_dones", dones64 - d0, 1);
        chk("t2_drained", exp64.size(), 0);

        // 3: backpressure, ready one cycle in three
        rdy_mode = 2;
        c0 = chars32; d0 = dones32;
        push32(32'hDEADBEEF, 1'b0, 1'b0);
        rv32 = 1'b0;
        wait_idle32(500);
        chk("t3_chars", chars32 - c0, 11);
        chk("t3_dones", dones32 - d0, 1);

        // 4: fill the queue while the UART stalls
        rdy_mode = 0;
        @(posedge clk); #1;
        c0 = chars32; d0 = dones32;
        for (int i = 0; i < 5; i++) push32(32'h1111_1111 * (i + 1), 1'(i % 2), 1'b0);
        rv32 = 1'b0;
        chk("t4_full", rr32, 0);
        chk("t4_busy", busy32, 1);
        chk("t4_stalled_valid", tv32, 1);
        rdy_mode = 1;
        wait_idle32(1000);
        chk("t4_dones", dones32 - d0, 5);
        chk("t4_chars", chars32 - c0, 11 * 5 + 2 * 2);
        chk("t4_drained", exp32.size(), 0);

        // 5: eolonly first, eol+eolonly combined, push/pop overlap keeps occupancy
        rdy_mode = 0;
        @(posedge clk); #1;
        c0 = chars32; d0 = dones32;
        push32(32'hFFFFFFFF, 1'b0, 1'b1);
        push32(32'h00C0FFEE, 1'b1, 1'b0);
        push32(32'h00000000, 1'b1, 1'b1);
        push32(32'h89ABCDEF, 1'b0, 1'b0);
        push32(32'h76543210, 1'b0, 1'b0);
        rv32 = 1'b0;
        chk("t5_full", rr32, 0);
        chk("t5_first_cr", tc32, 8'h0d);
        rdy_mode = 1;
        wait_idle32(1000);
        chk("t5_chars", chars32 - c0, 39);
        chk("t5_dones", dones32 - d0, 5);
        chk("t5_drained", exp32.size(), 0);

        // 6: reset in the middle of DIGIT
        rdy_mode = 0;
        @(posedge clk); #1;
        push32(32'h1234ABCD, 1'b1, 1'b0);
        rv32 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", tv32, 0);
        chk("t6_async_char", tc32, 8'h20);
        chk("t6_async_busy", busy32, 0);
        chk("t6_async_ready", rr32, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 1;
        c0 = chars32; d0 = dones32;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_silent_chars", chars32 - c0, 0);
        chk("t6_silent_valid", tv32, 0);
        push32(32'h00FF1234, 1'b0, 1'b0);
        rv32 = 1'b0;
        wait_idle32(200);
        chk("t6_chars", chars32 - c0, 11);
        chk("t6_dones", dones32 - d0, 1);
        chk("t6_drained", exp32.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
